oq_remove_sched: RTL

Round-robin remove scheduler for the SRAM packet-generator output queues. It sits directly downstream of the per-queue empty evaluator and consumes its `empty` vector. It picks the next non-empty, enabled queue whose output port can accept data, then issues one remove request at a time to the queue remover. After each remove it briefly masks the just-served queue, because that queue's empty bit lags the remove by several cycles.

---
 rtl/oq_remove_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/oq_remove_sched.sv
// Round-robin remove scheduler for the packet-generator output queues.
// Define OQ_REMOVE_SCHED_STRICT_PRIO_EN to switch arbitration to strict lowest-index priority.
module oq_remove_sched #(
    parameter int unsigned NUM_OUTPUT_QUEUES = 8,
    parameter int unsigned NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
    parameter int unsigned HOLDOFF_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_OUTPUT_QUEUES-1:0] empty,
    input  logic [NUM_OUTPUT_QUEUES-1:0] dst_ready,
    input  logic [NUM_OUTPUT_QUEUES-1:0] enable,
    output logic                         rm_req,
    output logic [NUM_OQ_WIDTH-1:0]      rm_oq,
    input  logic                         rm_ack,
    input  logic                         rm_done,
    output logic                         busy,
    output logic                         err_timeout,
    input  logic                         err_clear
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NUM_OQ_WIDTH-1:0]      hold_oq;
    logic [3:0]                   hold_cnt;
    logic [TW-1:0]                to_cnt;
    logic [NUM_OUTPUT_QUEUES-1:0] hold_mask;
    logic [NUM_OUTPUT_QUEUES-1:0] eligible;
    logic                         pick_valid;
    logic [NUM_OQ_WIDTH-1:0]      pick_oq;
    logic                         grant;
    logic                         complete;
    logic                         timeout;

`ifndef OQ_REMOVE_SCHED_STRICT_PRIO_EN
    logic [NUM_OQ_WIDTH-1:0]      last_oq;
    logic [NUM_OQ_WIDTH-1:0]      cand;
`endif

    // The served queue's empty bit lags the remove, so it is masked for a while.
    always_comb begin
        hold_mask = '0;
        if (hold_cnt != '0) begin
            hold_mask[hold_oq] = 1'b1;
        end
        eligible = ~empty & dst_ready & enable & ~hold_mask;
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_oq    = '0;
`ifdef OQ_REMOVE_SCHED_STRICT_PRIO_EN
        for (int unsigned i = NUM_OUTPUT_QUEUES; i > 0; i--) begin
            if (eligible[i-1]) begin
                pick_valid = 1'b1;
                pick_oq    = NUM_OQ_WIDTH'(i - 1);
            end
        end
`else
        cand = '0;
        // Scan downward so the candidate closest after last_oq overrides the rest.
        for (int unsigned k = NUM_OUTPUT_QUEUES; k > 0; k--) begin
            cand = NUM_OQ_WIDTH'((32'(last_oq) + k) % NUM_OUTPUT_QUEUES);
            if (eligible[cand]) begin
                pick_valid = 1'b1;
                pick_oq    = cand;
            end
        end
`endif
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    grant      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (rm_ack) begin
                    if (rm_done) begin
                        complete   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (rm_done) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rm_oq       <= '0;
            hold_oq     <= '0;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (grant) begin
                rm_oq <= pick_oq;
            end

            if (complete) begin
                hold_oq  <= rm_oq;
                hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end

            if (state == S_REQ) begin
                to_cnt <= '0;
            end else if (state == S_XFER && to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (timeout) begin
                err_timeout <= 1'b1;
            end else if (err_clear) begin
                err_timeout <= 1'b0;
            end
        end
    end

`ifndef OQ_REMOVE_SCHED_STRICT_PRIO_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_oq <= NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);
        end else if (grant) begin
            last_oq <= pick_oq;
        end
    end
`endif

    assign rm_req = (state == S_REQ);
    assign busy   = (state != S_IDLE);

endmodule
